// File: rtl/mpc_types.sv
// Shared types for the multi-channel ROB retire controller.
//   NUM_CH     : number of issue channels
//   ch_id_t    : binary channel id
//   rr_ptr_t   : round-robin pointer
//   mpc_cfg_t  : block configuration (robWidth -> per-channel ROB depth 2**robWidth)
//   ch_inc()   : next channel, modulo NUM_CH
package mpc_types;

    localparam int NUM_CH = 3;

    typedef logic [1:0] ch_id_t;
    typedef logic [1:0] rr_ptr_t;

    typedef struct packed {
        logic [7:0] robWidth;
    } mpc_cfg_t;

    function automatic ch_id_t ch_inc(input ch_id_t ch);
        return (ch == ch_id_t'(NUM_CH - 1)) ? ch_id_t'(0) : ch + ch_id_t'(1);
    endfunction

endpackage

// File: rtl/ns_gnrl_dfflr.sv
// Generic flop with load enable, async active-low reset to zero.
//   clk, rst_n : clock / async reset
//   lden       : load enable
//   dnxt       : next value (taken when lden)
//   qout       : registered value
module ns_gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    qout <= '0;
        else if (lden) qout <= dnxt;
    end
endmodule

// File: rtl/ns_gnrl_dffr.sv
// Generic flop, async active-low reset to zero, loads every cycle.
//   clk, rst_n : clock / async reset
//   dnxt       : next value
//   qout       : registered value
module ns_gnrl_dffr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) qout <= '0;
        else        qout <= dnxt;
    end
endmodule

// File: rtl/rob_chnl_tracker.sv
// Per-channel ROB tracking: allocated/done bitmaps, retire head and occupancy.
// All enables arrive pre-qualified by the top (illegal updates never reach here).
//   alloc_en/alloc_id : mark an entry allocated
//   done_en/done_id   : mark an entry completed
//   ret_en            : retire the head entry (clear bits, advance head)
//   alloc_bm, done_bm : registered bitmaps (used by the top for legality checks)
//   head, count       : retire pointer and occupancy
//   eligible          : head entry is allocated and done
module rob_chnl_tracker #(
    parameter int          IW = 2,
    parameter int unsigned D  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alloc_en,
    input  logic [IW-1:0]        alloc_id,
    input  logic                 done_en,
    input  logic [IW-1:0]        done_id,
    input  logic                 ret_en,
    output logic [(1<<IW)-1:0]   alloc_bm,
    output logic [(1<<IW)-1:0]   done_bm,
    output logic [IW-1:0]        head,
    output logic [IW:0]          count,
    output logic                 eligible
);
    localparam int BM = 1 << IW;
    localparam int CW = IW + 1;

    logic [BM-1:0] alloc_nxt, done_nxt;
    logic [IW-1:0] head_nxt;
    logic [CW-1:0] count_nxt;

    // Set and clear never hit the same bit: a set on an allocated/done entry
    // (including the retiring head) is rejected upstream.
    always_comb begin
        alloc_nxt = alloc_bm;
        done_nxt  = done_bm;
        if (alloc_en) alloc_nxt[alloc_id] = 1'b1;
        if (done_en)  done_nxt[done_id]   = 1'b1;
        if (ret_en) begin
            alloc_nxt[head] = 1'b0;
            done_nxt[head]  = 1'b0;
        end
    end

    // D need not equal 2**IW (degenerate configs), so wrap explicitly.
    assign head_nxt  = (head == IW'(D - 1)) ? '0 : head + IW'(1);
    assign count_nxt = alloc_en ? count + CW'(1) : count - CW'(1);

    ns_gnrl_dffr  #(.DW(BM)) u_alloc (.clk(clk), .rst_n(rst_n), .dnxt(alloc_nxt), .qout(alloc_bm));
    ns_gnrl_dffr  #(.DW(BM)) u_done  (.clk(clk), .rst_n(rst_n), .dnxt(done_nxt),  .qout(done_bm));
    ns_gnrl_dfflr #(.DW(IW)) u_head  (.clk(clk), .rst_n(rst_n), .lden(ret_en),
                                      .dnxt(head_nxt), .qout(head));
    // Simultaneous alloc + retire leaves the count unchanged.
    ns_gnrl_dfflr #(.DW(CW)) u_count (.clk(clk), .rst_n(rst_n), .lden(alloc_en ^ ret_en),
                                      .dnxt(count_nxt), .qout(count));

    assign eligible = alloc_bm[head] & done_bm[head];

endmodule

// File: rtl/rob_retire_ctrl.sv
// In-order retire controller for three independent per-channel ROBs.
// Tracks allocation/completion per channel and retires each channel's head
// in order, arbitrating round-robin across channels.
//   clk, rst_n                          : clock / async active-low reset
//   u_valid, u_channel_1hot_id, u_rob_id : issue (allocation) request
//   u_ready                             : per-channel not-full
//   c_valid, c_channel_id, c_rob_id     : completion report
//   d_valid, d_ready, d_channel_id, d_rob_id : retire handshake
//   err                                 : registered one-cycle protocol-violation pulse
module rob_retire_ctrl
    import mpc_types::*;
#(
    parameter mpc_cfg_t Cfg        = '0,
    parameter type      robWidth_t = logic
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       u_valid,
    input  logic [2:0] u_channel_1hot_id,
    input  robWidth_t  u_rob_id,
    output logic [2:0] u_ready,
    input  logic       c_valid,
    input  logic [1:0] c_channel_id,
    input  robWidth_t  c_rob_id,
    output logic       d_valid,
    input  logic       d_ready,
    output logic [1:0] d_channel_id,
    output robWidth_t  d_rob_id,
    output logic       err
);
    localparam int          IW = $bits(robWidth_t);
    localparam int unsigned D  = 1 << Cfg.robWidth;
    localparam int          BM = 1 << IW;
    localparam int          CW = IW + 1;

    logic [NUM_CH-1:0][BM-1:0] alloc_bm, done_bm;
    logic [NUM_CH-1:0][IW-1:0] head;
    logic [NUM_CH-1:0][CW-1:0] count;
    logic [NUM_CH-1:0]         eligible, alloc_en, alloc_bad, done_en, ret_en;

    logic [IW-1:0] u_id, c_id;
    logic          u_1hot, c_bad, err_nxt, hs;
    rr_ptr_t       rr_q;
    ch_id_t        scan, pick_ch, grant_ch, lock_ch_q;
    logic          pick_vld, lock_q;

    assign u_id   = u_rob_id;
    assign c_id   = c_rob_id;
    assign u_1hot = $onehot(u_channel_1hot_id);
    assign hs     = d_valid & d_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign u_ready[i] = count[i] < CW'(D);

        // Allocation into a full channel or onto a live entry is dropped.
        assign alloc_bad[i] = u_valid & u_1hot & u_channel_1hot_id[i]
                            & (~u_ready[i] | alloc_bm[i][u_id]);
        assign alloc_en[i]  = u_valid & u_1hot & u_channel_1hot_id[i] & ~alloc_bad[i];

        // A completion to the retiring head finds done=1 and is rejected here.
        assign done_en[i] = c_valid & (c_channel_id == ch_id_t'(i))
                          & alloc_bm[i][c_id] & ~done_bm[i][c_id];

        assign ret_en[i] = hs & (grant_ch == ch_id_t'(i));

        rob_chnl_tracker #(.IW(IW), .D(D)) u_trk (
            .clk      (clk),
            .rst_n    (rst_n),
            .alloc_en (alloc_en[i]),
            .alloc_id (u_id),
            .done_en  (done_en[i]),
            .done_id  (c_id),
            .ret_en   (ret_en[i]),
            .alloc_bm (alloc_bm[i]),
            .done_bm  (done_bm[i]),
            .head     (head[i]),
            .count    (count[i]),
            .eligible (eligible[i])
        );
    end

    // Any valid completion that did not land (bad channel, unallocated, or
    // already done) is a violation.
    assign c_bad   = c_valid & ~(|done_en);
    assign err_nxt = (u_valid & ~u_1hot) | (|alloc_bad) | c_bad;

    ns_gnrl_dffr #(.DW(1)) u_err (.clk(clk), .rst_n(rst_n), .dnxt(err_nxt), .qout(err));

    // Round-robin scan starting at rr_q.
    always_comb begin
        pick_vld = 1'b0;
        pick_ch  = '0;
        scan     = rr_q;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!pick_vld && eligible[scan]) begin
                pick_vld = 1'b1;
                pick_ch  = scan;
            end
            scan = ch_inc(scan);
        end
    end

    // Once offered, a grant is frozen until accepted. Channels becoming
    // eligible during a stall could otherwise steal the grant, since an
    // eligible head stays eligible until it retires.
    assign grant_ch = lock_q ? lock_ch_q : pick_ch;

    ns_gnrl_dffr #(.DW(1)) u_lock (.clk(clk), .rst_n(rst_n),
                                   .dnxt(d_valid & ~d_ready), .qout(lock_q));
    ns_gnrl_dffr #(.DW(2)) u_lock_ch (.clk(clk), .rst_n(rst_n),
                                      .dnxt(grant_ch), .qout(lock_ch_q));
    ns_gnrl_dfflr #(.DW(2)) u_rr (.clk(clk), .rst_n(rst_n), .lden(hs),
                                  .dnxt(ch_inc(grant_ch)), .qout(rr_q));

    assign d_valid      = |eligible;
    assign d_channel_id = grant_ch;
    assign d_rob_id     = robWidth_t'(head[grant_ch]);

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed bench for rob_retire_ctrl with robWidth=2 (D=4).
module tb_rob_retire_ctrl;
    import mpc_types::*;

    localparam mpc_cfg_t CFG = '{robWidth: 8'd2};

    logic       clk, rst_n;
    logic       u_valid;
    logic [2:0] u_ch1h;
    logic [1:0] u_id;
    logic [2:0] u_ready;
    logic       c_valid;
    logic [1:0] c_ch;
    logic [1:0] c_id;
    logic       d_valid, d_ready;
    logic [1:0] d_ch;
    logic [1:0] d_id;
    logic       err;

    int ncmp  = 0;
    int nfail = 0;

    rob_retire_ctrl #(.Cfg(CFG), .robWidth_t(logic [1:0])) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .u_valid           (u_valid),
        .u_channel_1hot_id (u_ch1h),
        .u_rob_id          (u_id),
        .u_ready           (u_ready),
        .c_valid           (c_valid),
        .c_channel_id      (c_ch),
        .c_rob_id          (c_id),
        .d_valid           (d_valid),
        .d_ready           (d_ready),
        .d_channel_id      (d_ch),
        .d_rob_id          (d_id),
        .err               (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed=%03b expected=%03b", tag, obs, exp);
        end
    endtask

    // Retire port check; channel/id only meaningful when valid is expected.
    task automatic chk_d(input string tag, input logic ev, input logic [1:0] ec, input logic [1:0] ei);
        chk1({tag, ".d_valid"}, d_valid, ev);
        if (ev) begin
            chk2({tag, ".d_channel_id"}, d_ch, ec);
            chk2({tag, ".d_rob_id"}, d_id, ei);
        end
    endtask

    task automatic alloc(input logic [2:0] ch, input logic [1:0] id);
        u_valid = 1'b1; u_ch1h = ch; u_id = id;
        tick();
        u_valid = 1'b0;
    endtask

    task automatic comp(input logic [1:0] ch, input logic [1:0] id);
        c_valid = 1'b1; c_ch = ch; c_id = id;
        tick();
        c_valid = 1'b0;
    endtask

    task automatic do_reset();
        u_valid = 1'b0; c_valid = 1'b0; d_ready = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; u_valid = 1'b0; u_ch1h = 3'b000; u_id = 2'd0;
        c_valid = 1'b0; c_ch = 2'd0; c_id = 2'd0; d_ready = 1'b0;
        #12;
        // Reset state
        chk_d("rst", 1'b0, 2'd0, 2'd0);
        chk2("rst.d_channel_id", d_ch, 2'd0);
        chk2("rst.d_rob_id", d_id, 2'd0);
        chk3("rst.u_ready", u_ready, 3'b111);
        chk1("rst.err", err, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();

        // In-order retire despite out-of-order completion
        alloc(3'b001, 2'd0); alloc(3'b001, 2'd1); alloc(3'b001, 2'd2);
        chk_d("ooo.alloc", 1'b0, 2'd0, 2'd0);
        comp(2'd0, 2'd2); chk_d("ooo.c2", 1'b0, 2'd0, 2'd0);
        comp(2'd0, 2'd1); chk_d("ooo.c1", 1'b0, 2'd0, 2'd0);
        comp(2'd0, 2'd0); chk_d("ooo.c0", 1'b1, 2'd0, 2'd0);
        chk1("ooo.err", err, 1'b0);
        d_ready = 1'b1;
        tick(); chk_d("ooo.r0", 1'b1, 2'd0, 2'd1);
        tick(); chk_d("ooo.r1", 1'b1, 2'd0, 2'd2);
        tick(); chk_d("ooo.r2", 1'b0, 2'd0, 2'd0);
        d_ready = 1'b0;

        // Full channel: head is 3 now
        alloc(3'b001, 2'd3); alloc(3'b001, 2'd0); alloc(3'b001, 2'd1);
        chk3("full.3", u_ready, 3'b111);
        alloc(3'b001, 2'd2);
        chk3("full.4", u_ready, 3'b110);
        comp(2'd0, 2'd3);
        chk_d("full.head", 1'b1, 2'd0, 2'd3);
        alloc(3'b001, 2'd0);
        chk1("full.err", err, 1'b1);
        chk3("full.still", u_ready, 3'b110);
        tick();
        chk1("full.err_clr", err, 1'b0);
        d_ready = 1'b1;
        tick();
        d_ready = 1'b0;
        chk3("full.retire", u_ready, 3'b111);
        chk_d("full.after", 1'b0, 2'd0, 2'd0);

        // Round robin across all three channels, with stall
        do_reset();
        alloc(3'b001, 2'd0); alloc(3'b010, 2'd0); alloc(3'b100, 2'd0);
        comp(2'd0, 2'd0); chk_d("rr.c0", 1'b1, 2'd0, 2'd0);
        comp(2'd1, 2'd0); comp(2'd2, 2'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_d("rr.stall", 1'b1, 2'd0, 2'd0);
        end
        d_ready = 1'b1;
        tick(); chk_d("rr.g1", 1'b1, 2'd1, 2'd0);
        tick(); chk_d("rr.g2", 1'b1, 2'd2, 2'd0);
        tick(); chk_d("rr.done", 1'b0, 2'd0, 2'd0);
        d_ready = 1'b0;

        // Grant frozen while a higher-priority channel becomes eligible (rr=0)
        alloc(3'b010, 2'd1); comp(2'd1, 2'd1);
        chk_d("lock.ch1", 1'b1, 2'd1, 2'd1);
        alloc(3'b001, 2'd1); comp(2'd0, 2'd1);
        chk_d("lock.hold", 1'b1, 2'd1, 2'd1);
        d_ready = 1'b1;
        tick(); chk_d("lock.next", 1'b1, 2'd0, 2'd1);
        tick(); chk_d("lock.empty", 1'b0, 2'd0, 2'd0);
        d_ready = 1'b0;

        // Channel 1 head wrap
        do_reset();
        for (int k = 0; k < 6; k++) begin
            alloc(3'b010, 2'(k % 4));
            comp(2'd1, 2'(k % 4));
            chk_d("wrap", 1'b1, 2'd1, 2'(k % 4));
            d_ready = 1'b1;
            tick();
            d_ready = 1'b0;
        end
        alloc(3'b010, 2'd2); comp(2'd1, 2'd2);
        chk_d("wrap.head", 1'b1, 2'd1, 2'd2);
        d_ready = 1'b1; tick(); d_ready = 1'b0;
        chk_d("wrap.empty", 1'b0, 2'd0, 2'd0);

        // Protocol violations
        comp(2'd2, 2'd3);
        chk1("err.unalloc", err, 1'b1);
        chk_d("err.unalloc", 1'b0, 2'd0, 2'd0);
        tick();
        chk1("err.pulse", err, 1'b0);
        alloc(3'b011, 2'd0);
        chk1("err.not1hot", err, 1'b1);
        chk3("err.not1hot.rdy", u_ready, 3'b111);
        comp(2'd3, 2'd0);
        chk1("err.ch3", err, 1'b1);
        alloc(3'b001, 2'd0); comp(2'd0, 2'd0);
        chk1("err.legal", err, 1'b0);
        comp(2'd0, 2'd0);
        chk1("err.dupdone", err, 1'b1);
        d_ready = 1'b1;
        comp(2'd0, 2'd0);
        d_ready = 1'b0;
        chk1("err.retiring", err, 1'b1);
        chk_d("err.retired", 1'b0, 2'd0, 2'd0);
        alloc(3'b001, 2'd1);
        chk1("err.ok", err, 1'b0);
        alloc(3'b001, 2'd1);
        chk1("err.dupalloc", err, 1'b1);

        // Alloc + retire on the same channel in one cycle (count 1 -> 1)
        comp(2'd0, 2'd1);
        d_ready = 1'b1;
        alloc(3'b001, 2'd2);
        d_ready = 1'b0;
        chk1("same.err", err, 1'b0);
        chk_d("same.head", 1'b0, 2'd0, 2'd0);
        alloc(3'b001, 2'd3); alloc(3'b001, 2'd0);
        chk3("same.cnt3", u_ready, 3'b111);
        alloc(3'b001, 2'd1);
        chk3("same.cnt4", u_ready, 3'b110);

        // Asynchronous reset mid-operation
        do_reset();
        alloc(3'b001, 2'd0); alloc(3'b001, 2'd1);
        comp(2'd0, 2'd0); comp(2'd0, 2'd1);
        chk_d("ares.pre", 1'b1, 2'd0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_d("ares.now", 1'b0, 2'd0, 2'd0);
        chk3("ares.rdy", u_ready, 3'b111);
        chk2("ares.d_rob_id", d_id, 2'd0);
        #2;
        rst_n = 1'b1;
        d_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_d("ares.post", 1'b0, 2'd0, 2'd0);
        end
        d_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
